pmodacl2_spi_master: RTL
========================

// Module: pmodacl2_spi_master
//
// PURPOSE
//  Host-side SPI master for the ADXL362 on the PmodACL2. It turns single-cycle command
//  requests into ADXL362 SPI transactions: register write (0x0A), register read (0x0B)
//  and FIFO read (0x0D). Read bytes are returned to the host one at a time.
//  Sits between host control logic (register/sample engine) and the SCLK/MOSI/MISO/nCS pins.
//  Uses SPI mode 0 (CPOL=0, CPHA=0), MSB first.
//
// PARAMETERS
//  CLK_DIV   8  clk cycles per SCLK half-period; SCLK = clk/(2*CLK_DIV); legal >= 2
//  CS_SETUP  4  clk cycles from nCS fall to the start of the first bit's low half
//  CS_HOLD   4  clk cycles from the last SCLK fall to nCS rise
//  CS_IDLE   8  minimum clk cycles nCS stays high before done and the next accept
//
// PORTS
//  clk          in   1  system clock; single clock domain
//  rst          in   1  synchronous, active-high reset
//  start        in   1  request strobe; accepted only when busy=0
//  op           in   2  00 write reg, 01 read reg, 10 read FIFO, 11 illegal
//  address      in   6  register address; sent as {2'b00,address}; ignored for FIFO read
//  wdata        in   8  write data for op=00
//  len          in   4  read ops: len+1 data bytes (1..16); ignored for writes
//  busy         out  1  high from the cycle after accept through the done cycle
//  done         out  1  one-cycle pulse at the end of a transaction
//  cmd_err      out  1  one-cycle pulse when start is seen with op=11
//  rdata        out  8  last received data byte; held until the next rdata_valid
//  rdata_valid  out  1  one-cycle pulse per received data byte
//  SCLK         out  1  SPI clock; idles low
//  MOSI         out  1  SPI data out
//  nCS          out  1  SPI chip select, active low
//  MISO         in   1  SPI data in
//
// BEHAVIOUR
//  Reset values: SCLK=0, MOSI=0, nCS=1, busy=done=cmd_err=rdata_valid=0, rdata=8'h00, state=IDLE.
//  States:
//   - IDLE -> SETUP on an accepted start (op != 11).
//   - op=11 in IDLE: stay in IDLE, pulse cmd_err, no pin activity.
//   - start while busy=1: ignored, no side effects.
//   - On accept, latch op/address/wdata/len.
//   - SETUP: nCS=0 from the cycle after accept; hold for CS_SETUP cycles -> SHIFT.
//   - SHIFT: for each bit, MOSI is driven at the start of the low half-period.
//     SCLK goes 0->1 after CLK_DIV cycles; MISO is sampled on that same clk edge.
//     SCLK goes 1->0 after another CLK_DIV cycles. Bit counter 0..7; byte counter runs up.
//   - Byte sequence:
//     - write: 0x0A, addr, wdata (3 bytes)
//     - read reg: 0x0B, addr, then len+1 dummy 0x00 bytes (MOSI=0)
//     - read FIFO: 0x0D, then len+1 dummy bytes
//   - Command and address bytes never produce rdata_valid.
//   - After bit 7 of each data byte in a read: rdata <= shifted byte and
//     rdata_valid=1 on the cycle after the last sample.
//   - After the last SCLK fall -> HOLD (CS_HOLD cycles, SCLK=0) -> nCS=1 -> CSIDLE
//     (CS_IDLE cycles) -> IDLE. done=1 on the last CSIDLE cycle; busy drops the cycle after.
//  nCS low time is exactly CS_SETUP + 16*CLK_DIV*nbytes + CS_HOLD cycles.
//  MOSI returns to 0 while nCS=1.
//  SCLK never toggles while nCS=1. No partial bytes occur.
//  Reset mid-transaction: on the next clk edge nCS=1, SCLK=0, MOSI=0, IDLE.
//   No done and no rdata_valid for the aborted transfer.
//  Max transfer: 2+16 bytes. Byte counter is 5 bits; no wrap.
//
// STRUCTURE
//  Shared defines header (with the existing ADXL362 register `defines):
//   - opcodes ADXL362_CMD_WRITE=8'h0A, ADXL362_CMD_READ=8'h0B, ADXL362_CMD_FIFO=8'h0D
//   - op encodings OP_WRITE/OP_READ/OP_FIFO/OP_ILLEGAL
//  State encodings are localparams in this file.
//  One sub-module is natural: pmodacl2_spi_shifter.
//   - Contents: 8-bit TX/RX shift register, bit counter, half-period divider.
//   - Handshake: load/byte_done.
//  FSM and byte sequencing stay in the top.
//
// TESTING (bench with the ADXL362 model, CLK_DIV=8, CS_SETUP=4, CS_HOLD=4, CS_IDLE=8)
//  1. op=00, address=0x2D, wdata=0x02
//     -> MOSI bytes 0A 2D 02; nCS low exactly 392 cycles; one done; POWER_CTL reads back 0x02.
//  2. op=01, address=0x00, len=0
//     -> one rdata_valid with rdata=0xAD (DEVID_AD); exactly 24 SCLK rises.
//  3. op=01, address=0x0E, len=5 after enabling measurement
//     -> 6 rdata_valid pulses, XDATA_L..ZDATA_H in order; 64 SCLK rises.
//  4. op=10, len=1 with FIFO enabled
//     -> MOSI first byte 0x0D; 2 rdata_valid pulses; model FIFO pops one 16-bit entry.
//  5. start pulsed while busy; op=11 in IDLE
//     -> second request ignored (byte count unchanged); cmd_err pulses 1 cycle; nCS stays 1.
//  6. rst asserted during byte 2 of a read
//     -> next cycle nCS=1, SCLK=0, MOSI=0; no done/rdata_valid; next write completes normally.

Source files
------------

// File: rtl/pmodacl2_spi_master_pkg.sv
// Shared ADXL362 opcodes and host op encodings for the PmodACL2 SPI master.
package pmodacl2_spi_master_pkg;

  localparam logic [7:0] ADXL362_CMD_WRITE = 8'h0A;
  localparam logic [7:0] ADXL362_CMD_READ  = 8'h0B;
  localparam logic [7:0] ADXL362_CMD_FIFO  = 8'h0D;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_FIFO    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_t;

  function automatic logic [7:0] op_cmd(input op_t o);
    case (o)
      OP_WRITE: op_cmd = ADXL362_CMD_WRITE;
      OP_READ:  op_cmd = ADXL362_CMD_READ;
      OP_FIFO:  op_cmd = ADXL362_CMD_FIFO;
      default:  op_cmd = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/pmodacl2_spi_shifter.sv
// One-byte SPI mode-0 shifter: half-period divider, bit counter, TX/RX shift registers.
module pmodacl2_spi_shifter #(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done,
  output logic       rx_done,
  output logic [7:0] rx_byte
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    tx_sr;
  logic [7:0]    rx_sr;
  logic          active;
  logic          half_end;

  assign half_end  = active && (div_cnt == '0);
  // rx_done marks the edge that samples bit 7; byte_done marks the final fall
  assign rx_done   = half_end && !sclk && (bit_cnt == 3'd7);
  assign byte_done = half_end &&  sclk && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr[6:0], miso};
  assign mosi      = active & tx_sr[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      sclk    <= 1'b0;
      active  <= 1'b0;
    end else if (load) begin
      tx_sr   <= tx_byte;
      bit_cnt <= '0;
      div_cnt <= DIV_MAX;
      sclk    <= 1'b0;
      active  <= 1'b1;
    end else if (active) begin
      if (div_cnt == '0) begin
        div_cnt <= DIV_MAX;
        if (!sclk) begin
          sclk  <= 1'b1;
          rx_sr <= {rx_sr[6:0], miso};
        end else begin
          sclk <= 1'b0;
          if (bit_cnt == 3'd7) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            tx_sr   <= {tx_sr[6:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmodacl2_spi_master.sv
// ADXL362 SPI master: accepts host commands, sequences command/address/data bytes and chip select.
//
//  state    | meaning
//  S_IDLE   | nCS high, waiting for start
//  S_SETUP  | nCS low, setup delay before first bit
//  S_SHIFT  | bytes shifting through the shifter
//  S_HOLD   | SCLK low after last fall, nCS still low
//  S_CSIDLE | nCS high, minimum deselect time; done on last cycle
module pmodacl2_spi_master
  import pmodacl2_spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_IDLE  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [5:0] address,
  input  logic [7:0] wdata,
  input  logic [3:0] len,
  output logic       busy,
  output logic       done,
  output logic       cmd_err,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       SCLK,
  output logic       MOSI,
  output logic       nCS,
  input  logic       MISO
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_CSIDLE} state_t;

  state_t     state, next_state;
  logic [7:0] cnt, cnt_nxt;
  logic [4:0] byte_idx, idx_nxt, last_idx;
  op_t        op_q;
  logic [5:0] addr_q;
  logic [7:0] wdata_q;
  logic       accept, load, byte_done, rx_done, data_byte;
  logic [7:0] tx_byte, rx_byte;

  assign accept    = start && (state == S_IDLE) && (op_t'(op) != OP_ILLEGAL);
  assign data_byte = ((op_q == OP_READ) && (byte_idx >= 5'd2)) ||
                     ((op_q == OP_FIFO) && (byte_idx >= 5'd1));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_CSIDLE) && (cnt == '0);
  assign nCS       = !((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD));

  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    idx_nxt    = byte_idx;
    load       = 1'b0;
    case (state)
      S_IDLE: if (accept) begin
        next_state = S_SETUP;
        cnt_nxt    = 8'(CS_SETUP - 1);
        idx_nxt    = '0;
      end
      S_SETUP: if (cnt == '0) begin
        next_state = S_SHIFT;
        load       = 1'b1;
      end else cnt_nxt = cnt - 8'd1;
      S_SHIFT: if (byte_done) begin
        if (byte_idx == last_idx) begin
          next_state = S_HOLD;
          cnt_nxt    = 8'(CS_HOLD - 1);
        end else begin
          load    = 1'b1;
          idx_nxt = byte_idx + 5'd1;
        end
      end
      S_HOLD: if (cnt == '0) begin
        next_state = S_CSIDLE;
        cnt_nxt    = 8'(CS_IDLE - 1);
      end else cnt_nxt = cnt - 8'd1;
      S_CSIDLE: if (cnt == '0) next_state = S_IDLE;
                else cnt_nxt = cnt - 8'd1;
      default: next_state = S_IDLE;
    endcase
  end

  // Byte to load is chosen by the index it will occupy once loaded
  always_comb begin
    tx_byte = 8'h00;
    if (idx_nxt == 5'd0)                             tx_byte = op_cmd(op_q);
    else if ((idx_nxt == 5'd1) && (op_q != OP_FIFO)) tx_byte = {2'b00, addr_q};
    else if ((idx_nxt == 5'd2) && (op_q == OP_WRITE)) tx_byte = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      byte_idx    <= '0;
      last_idx    <= '0;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= next_state;
      cnt         <= cnt_nxt;
      byte_idx    <= idx_nxt;
      rdata_valid <= rx_done && data_byte;
      cmd_err     <= start && (state == S_IDLE) && (op_t'(op) == OP_ILLEGAL);
      if (rx_done && data_byte) rdata <= rx_byte;
      if (accept) begin
        op_q    <= op_t'(op);
        addr_q  <= address;
        wdata_q <= wdata;
        case (op_t'(op))
          OP_WRITE: last_idx <= 5'd2;
          OP_READ:  last_idx <= {1'b0, len} + 5'd2;
          default:  last_idx <= {1'b0, len} + 5'd1;
        endcase
      end
    end
  end

  pmodacl2_spi_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .tx_byte   (tx_byte),
    .miso      (MISO),
    .sclk      (SCLK),
    .mosi      (MOSI),
    .byte_done (byte_done),
    .rx_done   (rx_done),
    .rx_byte   (rx_byte)
  );

endmodule
